// File: rtl/seq_rec_readout_ctrl_if.sv
// rtl/seq_rec_readout_ctrl_if.sv - 8-bit register/memory bus between the sequencer and seq_rec_core
interface seq_rec_readout_ctrl_if #(
  parameter int ABUSWIDTH = 16
);
  logic [ABUSWIDTH-1:0] M_ADD;
  logic [7:0]           M_DATA_OUT;
  logic                 M_WR;
  logic                 M_RD;
  logic [7:0]           M_DATA_IN;

  modport master (output M_ADD, output M_DATA_OUT, output M_WR, output M_RD, input M_DATA_IN);
  modport slave  (input M_ADD, input M_DATA_OUT, input M_WR, input M_RD, output M_DATA_IN);
endinterface

// File: rtl/seq_rec_readout_ctrl.sv
// rtl/seq_rec_readout_ctrl.sv - Configures, starts, polls and reads out one seq_rec_core into 32-bit FIFO words
module seq_rec_readout_ctrl #(
  parameter int ABUSWIDTH = 16,
  parameter int BASEADDR  = 0,
  parameter int MEM_BYTES = 8192,
  parameter int IN_BITS   = 8,
  parameter int POLL_GAP  = 16,
  parameter int TIMEOUT   = 2**20
) (
  input  logic        BUS_CLK,
  input  logic        RST,
  input  logic        CMD_START,
  input  logic [15:0] CMD_COUNT,
  input  logic        CMD_ABORT,
  output logic        BUSY,
  output logic        ERROR,
  seq_rec_readout_ctrl_if.master bus,
  output logic [31:0] FIFO_DATA,
  output logic        FIFO_WRITE,
  input  logic        FIFO_FULL
);
  localparam int IW = $clog2(MEM_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int PW = $clog2(POLL_GAP + 1);
  localparam logic [ABUSWIDTH-1:0] BASE = ABUSWIDTH'(BASEADDR);

  typedef enum logic [3:0] {
    S_IDLE, S_CFG_RST, S_CFG_EXT, S_CFG_CNTL, S_CFG_CNTH, S_ARM, S_WAIT_DONE,
    S_POLL_CHK, S_READ, S_CAPTURE, S_PUSH, S_FINISH, S_SRST
  } state_t;

  state_t          state, state_next;
  logic [15:0]     count;
  logic [31:0]     nbytes;
  logic [31:0]     start_nbytes;
  logic            start_ok;
  logic [IW-1:0]   idx;
  logic [TW-1:0]   tcnt;
  logic [PW-1:0]   ptmr;
  logic [31:0]     word;
  logic            in_wait;
  logic            timed_out;
  logic            last_byte;

  assign start_nbytes = 32'(CMD_COUNT) * 32'(IN_BITS / 8);
  assign start_ok     = (CMD_COUNT != 16'd0) && (start_nbytes <= 32'(MEM_BYTES));
  assign in_wait      = (state == S_WAIT_DONE) || (state == S_POLL_CHK);
  assign timed_out    = (tcnt == TW'(TIMEOUT));
  assign last_byte    = (32'(idx) == nbytes - 32'd1);
  assign BUSY         = (state != S_IDLE);
  assign FIFO_DATA    = word;

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:      if (CMD_START && !CMD_ABORT && start_ok) state_next = S_CFG_RST;
      S_CFG_RST:   state_next = S_CFG_EXT;
      S_CFG_EXT:   state_next = S_CFG_CNTL;
      S_CFG_CNTL:  state_next = S_CFG_CNTH;
      S_CFG_CNTH:  state_next = S_ARM;
      S_ARM:       state_next = S_WAIT_DONE;
      S_WAIT_DONE: if (timed_out) state_next = S_SRST;
                   else if (ptmr == '0) state_next = S_POLL_CHK;
      S_POLL_CHK:  if (timed_out) state_next = S_SRST;
                   else if (bus.M_DATA_IN[0]) state_next = S_READ;
                   else state_next = S_WAIT_DONE;
      S_READ:      state_next = S_CAPTURE;
      S_CAPTURE:   state_next = (idx[1:0] == 2'd3 || last_byte) ? S_PUSH : S_READ;
      S_PUSH:      if (!FIFO_FULL) state_next = (32'(idx) == nbytes) ? S_FINISH : S_READ;
      S_FINISH:    state_next = S_IDLE;
      S_SRST:      state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
    if (CMD_ABORT && state != S_IDLE && state != S_SRST) state_next = S_SRST;
  end

  // Strobes are decoded from the current state so that RST and CMD_ABORT can suppress them in their own cycle.
  always_comb begin
    bus.M_WR       = 1'b0;
    bus.M_RD       = 1'b0;
    bus.M_ADD      = '0;
    bus.M_DATA_OUT = 8'h00;
    FIFO_WRITE     = 1'b0;
    unique case (state)
      S_CFG_RST, S_SRST: begin bus.M_WR = 1'b1; bus.M_ADD = BASE; end
      S_CFG_EXT:   begin bus.M_WR = 1'b1; bus.M_ADD = BASE + ABUSWIDTH'(2); end
      S_CFG_CNTL:  begin bus.M_WR = 1'b1; bus.M_ADD = BASE + ABUSWIDTH'(3); bus.M_DATA_OUT = count[7:0]; end
      S_CFG_CNTH:  begin bus.M_WR = 1'b1; bus.M_ADD = BASE + ABUSWIDTH'(4); bus.M_DATA_OUT = count[15:8]; end
      S_ARM:       begin bus.M_WR = 1'b1; bus.M_ADD = BASE + ABUSWIDTH'(1); end
      S_WAIT_DONE: if (ptmr == '0 && !timed_out) begin bus.M_RD = 1'b1; bus.M_ADD = BASE + ABUSWIDTH'(1); end
      S_READ:      begin bus.M_RD = 1'b1; bus.M_ADD = BASE + ABUSWIDTH'(16) + ABUSWIDTH'(idx); end
      S_PUSH:      FIFO_WRITE = !FIFO_FULL;
      default:     ;
    endcase
    if (CMD_ABORT) begin
      bus.M_RD   = 1'b0;
      FIFO_WRITE = 1'b0;
    end
    if (RST) begin
      bus.M_WR       = 1'b0;
      bus.M_RD       = 1'b0;
      bus.M_ADD      = '0;
      bus.M_DATA_OUT = 8'h00;
      FIFO_WRITE     = 1'b0;
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      state  <= S_IDLE;
      ERROR  <= 1'b0;
      count  <= 16'd0;
      nbytes <= 32'd0;
      idx    <= '0;
      tcnt   <= '0;
      ptmr   <= '0;
      word   <= 32'd0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && CMD_START && !CMD_ABORT) begin
        if (start_ok) begin
          ERROR  <= 1'b0;
          count  <= CMD_COUNT;
          nbytes <= start_nbytes;
          idx    <= '0;
          word   <= 32'd0;
        end else begin
          ERROR <= 1'b1;
        end
      end
      if (state == S_ARM) begin
        ptmr <= PW'(POLL_GAP);
        tcnt <= '0;
      end
      if (in_wait && !timed_out) tcnt <= tcnt + TW'(1);
      if (state == S_WAIT_DONE && ptmr != '0) ptmr <= ptmr - PW'(1);
      // The check cycle itself is idle, so one fewer timer tick keeps polls POLL_GAP idle cycles apart.
      if (state == S_POLL_CHK) ptmr <= PW'(POLL_GAP - 1);
      if (in_wait && timed_out && !CMD_ABORT) ERROR <= 1'b1;
      if (state == S_CAPTURE && !CMD_ABORT) begin
        word[{idx[1:0], 3'b000} +: 8] <= bus.M_DATA_IN;
        idx <= idx + IW'(1);
      end
      if (FIFO_WRITE || state_next == S_SRST) word <= 32'd0;
    end
  end
endmodule

// File: tb/tb_seq_rec_readout_ctrl.sv
// tb/tb_seq_rec_readout_ctrl.sv - Self-checking bench: transaction-level model plus directed scenarios
module tb_seq_rec_readout_ctrl;
  localparam int TO = 64;
  localparam int PG = 16;

  logic BUS_CLK = 1'b0;
  always #5 BUS_CLK = ~BUS_CLK;

  logic        RST = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0, abort = 1'b0, full = 1'b0;
  logic [15:0] cmd_count = 16'd0;
  logic        busy0, err0, fw0, busy1, err1, fw1;
  logic [31:0] fd0, fd1;

  seq_rec_readout_ctrl_if #(.ABUSWIDTH(16)) bus0 ();
  seq_rec_readout_ctrl_if #(.ABUSWIDTH(16)) bus1 ();

  seq_rec_readout_ctrl #(.ABUSWIDTH(16), .BASEADDR(0), .MEM_BYTES(8192), .IN_BITS(8),
                         .POLL_GAP(PG), .TIMEOUT(TO)) dut0 (
    .BUS_CLK(BUS_CLK), .RST(RST), .CMD_START(start0), .CMD_COUNT(cmd_count), .CMD_ABORT(abort),
    .BUSY(busy0), .ERROR(err0), .bus(bus0), .FIFO_DATA(fd0), .FIFO_WRITE(fw0), .FIFO_FULL(full));

  seq_rec_readout_ctrl #(.ABUSWIDTH(16), .BASEADDR(0), .MEM_BYTES(8192), .IN_BITS(16),
                         .POLL_GAP(PG), .TIMEOUT(TO)) dut1 (
    .BUS_CLK(BUS_CLK), .RST(RST), .CMD_START(start1), .CMD_COUNT(cmd_count), .CMD_ABORT(abort),
    .BUSY(busy1), .ERROR(err1), .bus(bus1), .FIFO_DATA(fd1), .FIFO_WRITE(fw1), .FIFO_FULL(full));

  int tests = 0, fails = 0, cyc = 0;
  always @(posedge BUS_CLK) cyc <= cyc + 1;

  function automatic logic [7:0] mem_b(input int i);
    return 8'(32'hA0 + i);
  endfunction

  // Recorder models: DONE appears on poll number done_at (0 = never); read data one cycle after M_RD.
  int polls0 = 0, base0 = 0, done0 = 0;
  int polls1 = 0, base1 = 0, done1 = 1;
  always @(posedge BUS_CLK) begin
    if (bus0.M_RD && bus0.M_ADD == 16'd1) begin
      polls0 <= polls0 + 1;
      bus0.M_DATA_IN <= {7'd0, (done0 != 0) && (polls0 - base0 + 1 >= done0)};
    end else if (bus0.M_RD) bus0.M_DATA_IN <= mem_b(int'(bus0.M_ADD) - 16);
    else bus0.M_DATA_IN <= 8'($urandom);
    if (bus1.M_RD && bus1.M_ADD == 16'd1) begin
      polls1 <= polls1 + 1;
      bus1.M_DATA_IN <= {7'd0, (done1 != 0) && (polls1 - base1 + 1 >= done1)};
    end else if (bus1.M_RD) bus1.M_DATA_IN <= mem_b(int'(bus1.M_ADD) - 16);
    else bus1.M_DATA_IN <= 8'($urandom);
  end

  typedef struct packed {
    logic [1:0]  kind;   // 0 write, 1 read, 2 push
    logic [15:0] addr;
    logic [31:0] data;
  } ev_t;
  ev_t expq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic chk_ev(input logic [1:0] k, input logic [15:0] a, input logic [31:0] d);
    ev_t e;
    tests++;
    if (expq.size() == 0) begin
      fails++;
      $display("FAIL bus_event: got kind %0d addr %h data %h, required no event", k, a, d);
    end else begin
      e = expq.pop_front();
      if (e.kind !== k || e.addr !== a || e.data !== d) begin
        fails++;
        $display("FAIL bus_event: got kind %0d addr %h data %h, required kind %0d addr %h data %h",
                 k, a, d, e.kind, e.addr, e.data);
      end
    end
  endtask

  function automatic ev_t mk(input int k, input int a, input logic [31:0] d);
    ev_t e;
    e.kind = 2'(k);
    e.addr = 16'(a);
    e.data = d;
    return e;
  endfunction

  // Expected transaction list: config writes, polls, byte reads packed little-endian, optional soft reset.
  task automatic expect_run(input int count, input int in_bits, input int npolls, input int stop_byte,
                            input bit srst);
    int nb, nr;
    logic [31:0] w;
    nb = count * in_bits / 8;
    nr = (stop_byte < 0) ? nb : stop_byte;
    expq.push_back(mk(0, 0, 0));
    expq.push_back(mk(0, 2, 0));
    expq.push_back(mk(0, 3, count % 256));
    expq.push_back(mk(0, 4, (count / 256) % 256));
    expq.push_back(mk(0, 1, 0));
    for (int p = 0; p < npolls; p++) expq.push_back(mk(1, 1, 0));
    w = 32'd0;
    for (int b = 0; b < nr; b++) begin
      expq.push_back(mk(1, 16 + b, 0));
      w[8*(b%4) +: 8] = mem_b(b);
      if (b % 4 == 3 || b == nb - 1) begin
        expq.push_back(mk(2, 0, w));
        w = 32'd0;
      end
    end
    if (srst) expq.push_back(mk(0, 0, 0));
  endtask

  int arm_cyc = 0, reg0_cyc = 0;
  int poll_cyc[$], rd_cyc[$], push_cyc[$];
  logic [31:0] push_word[$];
  int strobes1 = 0, memrd1 = 0;
  logic [31:0] push1_word[$];

  always @(negedge BUS_CLK) begin
    chk("wr_rd_exclusive", 32'(bus0.M_WR & bus0.M_RD), 32'd0);
    chk("push_while_full", 32'(fw0 & full), 32'd0);
    if (bus0.M_WR) begin
      chk_ev(2'd0, bus0.M_ADD, 32'(bus0.M_DATA_OUT));
      if (bus0.M_ADD == 16'd1) arm_cyc = cyc;
      if (bus0.M_ADD == 16'd0) reg0_cyc = cyc;
    end
    if (bus0.M_RD) begin
      chk_ev(2'd1, bus0.M_ADD, 32'd0);
      if (bus0.M_ADD == 16'd1) poll_cyc.push_back(cyc);
      else rd_cyc.push_back(cyc);
    end
    if (fw0) begin
      chk_ev(2'd2, 16'd0, fd0);
      push_cyc.push_back(cyc);
      push_word.push_back(fd0);
    end
    if (bus1.M_WR || bus1.M_RD || fw1) strobes1++;
    if (bus1.M_RD && bus1.M_ADD >= 16'd16) memrd1++;
    if (fw1) push1_word.push_back(fd1);
  end

  task automatic start_cmd(input int which, input int c);
    @(posedge BUS_CLK); #1;
    cmd_count = 16'(c);
    if (which == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge BUS_CLK); #1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_idle(input int which, input int budget, input string nm);
    for (int n = 0; n < budget; n++) begin
      @(negedge BUS_CLK);
      if (((which == 0) ? busy0 : busy1) == 1'b0) break;
    end
    chk(nm, 32'((which == 0) ? busy0 : busy1), 32'd0);
  endtask

  task automatic wait_rd0(input int addr, input int budget, input string nm);
    bit found;
    found = 1'b0;
    for (int n = 0; n < budget && !found; n++) begin
      @(negedge BUS_CLK);
      if (bus0.M_RD && bus0.M_ADD == 16'(addr)) found = 1'b1;
    end
    chk(nm, 32'(found), 32'd1);
  endtask

  initial begin
    int pb, pp, rb, np, full_cyc, n_in_win, s1, m1, q1;
    repeat (3) @(posedge BUS_CLK);
    #1 RST = 1'b0;
    @(negedge BUS_CLK);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_error", 32'(err0), 32'd0);
    chk("rst_m_wr", 32'(bus0.M_WR), 32'd0);
    chk("rst_m_rd", 32'(bus0.M_RD), 32'd0);
    chk("rst_fifo_write", 32'(fw0), 32'd0);
    chk("rst_m_add", 32'(bus0.M_ADD), 32'd0);
    chk("rst_m_data_out", 32'(bus0.M_DATA_OUT), 32'd0);
    chk("rst_fifo_data", fd0, 32'd0);

    // Normal run: 6 bytes, DONE on third poll.
    done0 = 3; base0 = polls0;
    pb = push_cyc.size(); pp = poll_cyc.size(); rb = rd_cyc.size();
    expect_run(6, 8, 3, -1, 1'b0);
    start_cmd(0, 6);
    wait_idle(0, 300, "run6_idle");
    chk("run6_drained", 32'(expq.size()), 32'd0);
    chk("run6_error", 32'(err0), 32'd0);
    chk("run6_word0", push_word[pb], 32'hA3A2A1A0);
    chk("run6_word1", push_word[pb+1], 32'h0000A5A4);
    chk("run6_poll1_cyc", 32'(poll_cyc[pp] - arm_cyc), 32'd17);
    chk("run6_poll2_cyc", 32'(poll_cyc[pp+1] - arm_cyc), 32'd34);
    chk("run6_poll3_cyc", 32'(poll_cyc[pp+2] - arm_cyc), 32'd51);
    chk("run6_rd0_cyc", 32'(rd_cyc[rb] - arm_cyc), 32'd53);
    chk("run6_push0_cyc", 32'(push_cyc[pb] - arm_cyc), 32'd61);
    chk("run6_push1_cyc", 32'(push_cyc[pb+1] - arm_cyc), 32'd66);

    // Rejected counts: no bus traffic, sticky error, never busy.
    start_cmd(0, 0);
    @(negedge BUS_CLK);
    chk("cnt0_busy", 32'(busy0), 32'd0);
    repeat (4) @(negedge BUS_CLK);
    chk("cnt0_error", 32'(err0), 32'd1);
    start_cmd(0, 8193);
    @(negedge BUS_CLK);
    chk("cnt8193_busy", 32'(busy0), 32'd0);
    repeat (4) @(negedge BUS_CLK);
    chk("cnt8193_error", 32'(err0), 32'd1);

    // Timeout: DONE never set.
    done0 = 0; base0 = polls0;
    np = 0;
    for (int t = PG; t < TO; t += PG + 1) np++;
    pb = push_cyc.size();
    expect_run(3, 8, np, 0, 1'b1);
    start_cmd(0, 3);
    @(negedge BUS_CLK);
    chk("tmo_err_cleared", 32'(err0), 32'd0);
    wait_idle(0, 300, "tmo_idle");
    chk("tmo_drained", 32'(expq.size()), 32'd0);
    chk("tmo_error", 32'(err0), 32'd1);
    chk("tmo_srst_cyc", 32'(reg0_cyc - arm_cyc), 32'd66);
    chk("tmo_no_push", 32'(push_cyc.size() - pb), 32'd0);

    // FIFO full for 20 cycles at the first push.
    done0 = 1; base0 = polls0;
    pb = push_cyc.size();
    expect_run(6, 8, 1, -1, 1'b0);
    start_cmd(0, 6);
    @(negedge BUS_CLK);
    chk("full_err_cleared", 32'(err0), 32'd0);
    wait_rd0(19, 200, "full_saw_rd19");
    @(posedge BUS_CLK); #1;
    full = 1'b1;
    full_cyc = cyc;
    repeat (20) @(posedge BUS_CLK);
    #1 full = 1'b0;
    wait_idle(0, 200, "full_idle");
    n_in_win = 0;
    foreach (rd_cyc[k]) if (rd_cyc[k] >= full_cyc && rd_cyc[k] < full_cyc + 20) n_in_win++;
    chk("full_no_rd", 32'(n_in_win), 32'd0);
    chk("full_push_cyc", 32'(push_cyc[pb] - full_cyc), 32'd20);
    chk("full_drained", 32'(expq.size()), 32'd0);

    // Abort while reading byte 2.
    done0 = 1; base0 = polls0;
    pb = push_cyc.size();
    expect_run(6, 8, 1, 2, 1'b1);
    start_cmd(0, 6);
    wait_rd0(17, 200, "abort_saw_rd17");
    @(posedge BUS_CLK); #1;
    @(posedge BUS_CLK); #1;
    abort = 1'b1;
    @(posedge BUS_CLK); #1;
    abort = 1'b0;
    wait_idle(0, 50, "abort_idle");
    chk("abort_drained", 32'(expq.size()), 32'd0);
    chk("abort_no_push", 32'(push_cyc.size() - pb), 32'd0);
    chk("abort_error", 32'(err0), 32'd0);

    done0 = 2; base0 = polls0;
    expect_run(6, 8, 2, -1, 1'b0);
    start_cmd(0, 6);
    wait_idle(0, 300, "rerun_idle");
    chk("rerun_drained", 32'(expq.size()), 32'd0);
    chk("rerun_error", 32'(err0), 32'd0);

    // Largest legal count accepted, then RST mid-configuration.
    expq.push_back(mk(0, 0, 0));
    expq.push_back(mk(0, 2, 0));
    start_cmd(0, 8192);
    @(negedge BUS_CLK);
    chk("cnt8192_busy", 32'(busy0), 32'd1);
    @(posedge BUS_CLK); #1;
    @(posedge BUS_CLK); #1;
    RST = 1'b1;
    @(negedge BUS_CLK);
    chk("rst_cycle_no_wr", 32'(bus0.M_WR), 32'd0);
    @(posedge BUS_CLK); #1;
    RST = 1'b0;
    @(negedge BUS_CLK);
    chk("midrst_busy", 32'(busy0), 32'd0);
    chk("midrst_drained", 32'(expq.size()), 32'd0);

    // 16-bit samples.
    done1 = 1; base1 = polls1;
    s1 = strobes1; m1 = memrd1; q1 = push1_word.size();
    start_cmd(1, 4);
    wait_idle(1, 300, "w16_idle");
    chk("w16_reads", 32'(memrd1 - m1), 32'd8);
    chk("w16_pushes", 32'(push1_word.size() - q1), 32'd2);
    chk("w16_word0", push1_word[q1], 32'hA3A2A1A0);
    chk("w16_word1", push1_word[q1+1], 32'hA7A6A5A4);
    chk("w16_error", 32'(err1), 32'd0);
    s1 = strobes1;
    start_cmd(1, 5000);
    repeat (5) @(negedge BUS_CLK);
    chk("w16_5000_error", 32'(err1), 32'd1);
    chk("w16_5000_busy", 32'(busy1), 32'd0);
    chk("w16_5000_strobes", 32'(strobes1 - s1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end
endmodule
